// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared types, tap masks and feedback helper for the PRBS generator/checker
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

    // Masks for this right-shifting Fibonacci form: bit 0 plus bit (W - n) for x^W + x^n + 1.
    localparam logic [31:0] TAPS_W4  = 32'h0000_0009;
    localparam logic [31:0] TAPS_W7  = 32'h0000_0003;
    localparam logic [31:0] TAPS_W15 = 32'h0000_0003;
    localparam logic [31:0] TAPS_W23 = 32'h0000_0021;
    localparam logic [31:0] TAPS_W31 = 32'h0000_0009;

    function automatic logic lfsr_fb(input logic [31:0] state, input logic [31:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/prbs_gen_chk_lfsr_core.sv
// rtl/prbs_gen_chk_lfsr_core.sv - shift register with seed load, step enable and external shift-in
module lfsr_core
    import prbs_pkg::*;
#(
    parameter int           W       = 4,
    parameter logic [W-1:0] TAPS    = 4'b1001,
    parameter logic [W-1:0] RST_VAL = {W{1'b1}}
) (
    input  logic         clk_i,
    input  logic         res_i,
    input  logic         load_i,
    input  logic [W-1:0] seed_i,
    input  logic         step_i,
    input  logic         shift_in_i,
    output logic [W-1:0] d_next_o,
    output logic         y_o,
    output logic         fb_o
);

    logic [W-1:0] d_q;
    logic [W-1:0] d_d;

    // An all-zero seed would lock the register up, so it is replaced by all-ones.
    always_comb begin
        d_d = d_q;
        if (load_i) begin
            d_d = (seed_i == '0) ? {W{1'b1}} : seed_i;
        end else if (step_i) begin
            d_d = {shift_in_i, d_q[W-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            d_q <= RST_VAL;
        end else begin
            d_q <= d_d;
        end
    end

    assign d_next_o = d_d;
    assign y_o      = d_q[0];
    assign fb_o     = lfsr_fb(32'(d_q), 32'(TAPS));

endmodule

// File: rtl/prbs_gen_chk.sv
// rtl/prbs_gen_chk.sv - PRBS pattern generator plus self-synchronising bit-error checker
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int           W      = 4,
    parameter logic [W-1:0] TAPS   = 4'b1001,
    parameter logic [W-1:0] SEED   = {W{1'b1}},
    parameter int           LOCK_N = 8,
    parameter int           LOSS_N = 4,
    parameter int           CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [W-1:0]     seed_i,
    output logic             y_o,
    output logic             wrap_o,
    input  logic             chk_din_i,
    input  logic             chk_vld_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    input  logic             err_clr_i
);

    localparam logic [W-1:0] SEED_SAFE = (SEED == '0) ? {W{1'b1}} : SEED;
    localparam int           FW        = $clog2(W + 1);
    localparam int           RW        = $clog2(LOCK_N + 1);
    localparam int           MW        = $clog2(LOSS_N + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(W - 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'(LOCK_N - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_N - 1);

    logic [W-1:0] gen_dnext;
    logic         gen_y;
    logic         gen_fb;
    logic [W-1:0] act_seed_q;
    logic         wrap_q;

    lfsr_core #(
        .W       (W),
        .TAPS    (TAPS),
        .RST_VAL (SEED_SAFE)
    ) u_gen (
        .clk_i      (clk_i),
        .res_i      (res_i),
        .load_i     (load_i),
        .seed_i     (seed_i),
        .step_i     (en_i),
        .shift_in_i (gen_fb),
        .d_next_o   (gen_dnext),
        .y_o        (gen_y),
        .fb_o       (gen_fb)
    );

    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            act_seed_q <= SEED_SAFE;
            wrap_q     <= 1'b0;
        end else begin
            if (load_i) begin
                act_seed_q <= (seed_i == '0) ? {W{1'b1}} : seed_i;
            end
            wrap_q <= en_i & ~load_i & (gen_dnext == act_seed_q);
        end
    end

    chk_state_e       state_q;
    logic [FW-1:0]    fill_q;
    logic [RW-1:0]    run_q;
    logic [MW-1:0]    miss_q;
    logic             locked_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             chk_pred;
    logic             chk_shift_in;
    logic             chk_match;
    logic [W-1:0]     chk_dnext;
    logic             chk_y;
    logic             unused_chk;

    // Once locked the register follows its own prediction, so a bad bit cannot pollute it.
    assign chk_shift_in = (state_q == ST_LOCKED) ? chk_pred : chk_din_i;
    assign chk_match    = (chk_din_i == chk_pred);
    assign unused_chk   = ^{chk_dnext, chk_y};

    lfsr_core #(
        .W       (W),
        .TAPS    (TAPS),
        .RST_VAL ({W{1'b0}})
    ) u_chk (
        .clk_i      (clk_i),
        .res_i      (res_i),
        .load_i     (1'b0),
        .seed_i     ({W{1'b0}}),
        .step_i     (chk_vld_i),
        .shift_in_i (chk_shift_in),
        .d_next_o   (chk_dnext),
        .y_o        (chk_y),
        .fb_o       (chk_pred)
    );

    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            state_q  <= ST_FILL;
            fill_q   <= '0;
            run_q    <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            err_q <= 1'b0;
            if (err_clr_i) begin
                cnt_q <= '0;
            end
            if (chk_vld_i) begin
                unique case (state_q)
                    ST_FILL: begin
                        fill_q <= fill_q + FW'(1);
                        if (fill_q == FILL_LAST) begin
                            state_q <= ST_SEARCH;
                            run_q   <= '0;
                        end
                    end
                    ST_SEARCH: begin
                        if (chk_match) begin
                            run_q <= run_q + RW'(1);
                            if (run_q == RUN_LAST) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                                miss_q   <= '0;
                            end
                        end else begin
                            run_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (!chk_match) begin
                            err_q  <= 1'b1;
                            miss_q <= miss_q + MW'(1);
                            if (!err_clr_i && (cnt_q != {CNT_W{1'b1}})) begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                            if (miss_q == MISS_LAST) begin
                                state_q  <= ST_FILL;
                                locked_q <= 1'b0;
                                fill_q   <= '0;
                            end
                        end else begin
                            miss_q <= '0;
                        end
                    end
                    default: state_q <= ST_FILL;
                endcase
            end
        end
    end

    assign y_o       = gen_y;
    assign wrap_o    = wrap_q;
    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb/tb_prbs_gen_chk.sv - self-checking bench for prbs_gen_chk (generator table, random model, checker sequences)
module tb_prbs_gen_chk;

    logic        clk = 1'b0;
    logic        res;
    logic        en;
    logic        load;
    logic [3:0]  seed;
    logic        chk_din;
    logic        chk_vld;
    logic        err_clr;
    logic        y,  wrap,  locked,  err;
    logic [15:0] err_cnt;
    logic        y4, wrap4, locked4, err4;
    logic [3:0]  err_cnt4;

    int n_pass  = 0;
    int n_total = 0;
    int err_pulses = 0;

    always #5 clk = ~clk;

    prbs_gen_chk dut (
        .clk_i(clk), .res_i(res), .en_i(en), .load_i(load), .seed_i(seed),
        .y_o(y), .wrap_o(wrap), .chk_din_i(chk_din), .chk_vld_i(chk_vld),
        .locked_o(locked), .err_o(err), .err_cnt_o(err_cnt), .err_clr_i(err_clr)
    );

    prbs_gen_chk #(.CNT_W(4)) dut4 (
        .clk_i(clk), .res_i(res), .en_i(en), .load_i(load), .seed_i(seed),
        .y_o(y4), .wrap_o(wrap4), .chk_din_i(chk_din), .chk_vld_i(chk_vld),
        .locked_o(locked4), .err_o(err4), .err_cnt_o(err_cnt4), .err_clr_i(err_clr)
    );

    always @(negedge clk) begin
        if (res === 1'b1 && err === 1'b1) err_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic       en;
        logic       load;
        logic [3:0] seed;
        logic       exp_y;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    // Sequence from the all-ones seed, derived from b[k+4] = b[k] ^ b[k+3].
    logic seq_c [15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Bit k of the stream started from seed s: the first four bits are the seed bits, the rest follow the tap recurrence.
    function automatic logic ref_bit(input logic [3:0] s, input int k);
        logic b[$];
        for (int i = 0; i < 4; i++) b.push_back(s[i]);
        for (int j = 4; j <= k; j++) b.push_back(b[j-4] ^ b[j-1]);
        return b[k];
    endfunction

    function automatic vec_t mk(input logic e, input logic l, input logic [3:0] s,
                                input logic ey, input logic ew);
        vec_t v;
        v.en = e; v.load = l; v.seed = s; v.exp_y = ey; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        res = 1'b0; en = 1'b0; load = 1'b0; chk_vld = 1'b0; err_clr = 1'b0; chk_din = 1'b0;
        @(negedge clk);
        res = 1'b1;
    endtask

    task automatic step(input logic flip);
        en = 1'b1;
        load = 1'b0;
        chk_vld = 1'b1;
        chk_din = y ^ flip;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] m_s;
        int         m_k;
        logic       m_wrap;
        logic       r_en, r_load;
        logic [3:0] r_seed;
        int         exp16, exp4;

        res = 1'b0; en = 1'b0; load = 1'b0; seed = 4'd0;
        chk_din = 1'b0; chk_vld = 1'b0; err_clr = 1'b0;

        for (int k = 0; k < 16; k++) vecs.push_back(mk(1'b1, 1'b0, 4'd0, seq_c[k % 15], k == 15));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, seq_c[1], 1'b0));
        for (int k = 0; k < 16; k++) vecs.push_back(mk(1'b1, 1'b0, 4'd0, seq_c[k % 15], k == 15));
        vecs.push_back(mk(1'b1, 1'b1, 4'b0110, seq_c[1], 1'b0));
        for (int k = 0; k < 16; k++) vecs.push_back(mk(1'b1, 1'b0, 4'd0, ref_bit(4'b0110, k % 15), k == 15));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, ref_bit(4'b0110, 1), 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, ref_bit(4'b0110, 1), 1'b0));

        @(negedge clk);
        check("rst_y", y, 1);
        check("rst_wrap", wrap, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_cnt4", err_cnt4, 0);
        res = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en; load = vecs[i].load; seed = vecs[i].seed;
            check($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
            check($sformatf("vec%0d_wrap", i), wrap, vecs[i].exp_wrap);
            @(negedge clk);
        end

        m_s = 4'b0110; m_k = 16; m_wrap = 1'b0;
        for (int i = 0; i < 300; i++) begin
            r_en   = ($urandom_range(0, 9) < 7);
            r_load = ($urandom_range(0, 19) == 0);
            r_seed = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            en = r_en; load = r_load; seed = r_seed;
            check($sformatf("rnd%0d_y", i), y, ref_bit(m_s, m_k % 15));
            check($sformatf("rnd%0d_wrap", i), wrap, m_wrap);
            if (r_load) begin
                m_s = (r_seed == 4'd0) ? 4'hF : r_seed;
                m_k = 0;
                m_wrap = 1'b0;
            end else if (r_en) begin
                m_k++;
                m_wrap = (m_k % 15 == 0);
            end else begin
                m_wrap = 1'b0;
            end
            @(negedge clk);
        end

        do_reset();
        for (int i = 0; i < 11; i++) step(1'b0);
        check("lock_after_11", locked, 0);
        step(1'b0);
        check("lock_after_12", locked, 1);
        check("lock4_after_12", locked4, 1);

        for (int i = 0; i < 1000; i++) step(1'b0);
        check("clean_err_cnt", err_cnt, 0);
        check("clean_pulses", err_pulses, 0);
        check("clean_locked", locked, 1);

        step(1'b1);
        check("single_err_pulse", err, 1);
        step(1'b0);
        check("single_err_gone", err, 0);
        check("single_err_cnt", err_cnt, 1);
        check("single_locked", locked, 1);
        check("single_pulses", err_pulses, 1);

        for (int i = 0; i < 3; i++) step(1'b1);
        check("burst3_locked", locked, 1);
        step(1'b1);
        check("burst4_unlocked", locked, 0);
        check("burst4_err_cnt", err_cnt, 5);
        check("burst4_err_cnt4", err_cnt4, 5);
        for (int i = 0; i < 11; i++) step(1'b0);
        check("relock_after_11", locked, 0);
        step(1'b0);
        check("relock_after_12", locked, 1);
        check("burst_pulses", err_pulses, 5);

        exp16 = 5; exp4 = 5;
        for (int e = 0; e < 20; e++) begin
            step(1'b1);
            exp16++;
            if (exp4 < 15) exp4++;
            check($sformatf("sat_err%0d_cnt4", e), err_cnt4, exp4);
            repeat ($urandom_range(1, 5)) step(1'b0);
        end
        check("sat_err_cnt16", err_cnt, exp16);
        check("sat_err_cnt4_final", err_cnt4, 15);
        check("sat_locked", locked, 1);

        err_clr = 1'b1;
        step(1'b1);
        err_clr = 1'b0;
        check("clr_err_pulse", err, 1);
        check("clr_err_cnt", err_cnt, 0);
        check("clr_err_cnt4", err_cnt4, 0);
        step(1'b0);
        check("clr_err_cnt_hold", err_cnt, 0);

        step(1'b1);
        check("pre_rst_err", err, 1);
        check("pre_rst_cnt", err_cnt, 1);
        #2 res = 1'b0;
        #1;
        check("async_rst_locked", locked, 0);
        check("async_rst_err", err, 0);
        check("async_rst_cnt", err_cnt, 0);
        check("async_rst_cnt4", err_cnt4, 0);
        @(negedge clk);
        res = 1'b1; en = 1'b1; chk_vld = 1'b0; load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("restart_y%0d", i), y, seq_c[i]);
            @(negedge clk);
        end
        check("restart_locked", locked, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
